// File: rtl/risc_dmem_arbiter.sv
// Data-memory port arbiter: shares one single-port RAM between the pipeline
// MEM stage and an external loader/debug master, with bounded-wait preemption.
module risc_dmem_arbiter #(
  parameter int unsigned AW       = 6,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_WAIT = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p_req,
  input  logic          p_we,
  input  logic [31:0]   p_addr,
  input  logic [DW-1:0] p_wdata,
  output logic [DW-1:0] p_rdata,
  output logic          stall_req,
  input  logic          x_valid,
  output logic          x_ready,
  input  logic          x_we,
  input  logic [AW-1:0] x_addr,
  input  logic [DW-1:0] x_wdata,
  output logic          x_rvalid,
  output logic [DW-1:0] x_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  localparam int unsigned CntW = 4;

  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : gBadMaxWait
    $error("risc_dmem_arbiter: MAX_WAIT must be in 1..15");
  end

  logic [CntW-1:0] waitCnt;
  logic            waitFull;
  logic            extGrant;
  logic            rdAccept;
  logic [AW-1:0]   pWordAddr;
  logic            unusedAddrBits;

  assign pWordAddr      = p_addr[AW+1:2];
  assign unusedAddrBits = ^{p_addr[31:AW+2], p_addr[1:0]};

  // External master wins when the pipeline is idle or it has waited long enough
  assign waitFull  = (waitCnt == CntW'(MAX_WAIT));
  assign extGrant  = x_valid & (~p_req | waitFull);
  assign x_ready   = extGrant;
  assign stall_req = p_req & extGrant;
  assign rdAccept  = extGrant & ~x_we;

  assign mem_addr = extGrant ? x_addr  : pWordAddr;
  assign mem_wd   = extGrant ? x_wdata : p_wdata;
  assign mem_we   = extGrant ? x_we    : (p_req & p_we);
  assign p_rdata  = mem_rd;

  // Refusal counter; clearing on grant makes back-to-back preemption impossible
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waitCnt <= '0;
    end else if (!x_valid || extGrant) begin
      waitCnt <= '0;
    end else if (!waitFull) begin
      waitCnt <= waitCnt + CntW'(1);
    end
  end

  // One-cycle registered read response for the external master
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_rvalid <= 1'b0;
      x_rdata  <= '0;
    end else begin
      x_rvalid <= rdAccept;
      if (rdAccept) begin
        x_rdata <= mem_rd;
      end
    end
  end

endmodule

// File: tb/tb_risc_dmem_arbiter.sv
// Scoreboard bench for risc_dmem_arbiter: a reference arbitration model plus a
// shadow memory predict every port value and queue expected read responses.
module tb_risc_dmem_arbiter;

  localparam int unsigned AW       = 6;
  localparam int unsigned DW       = 32;
  localparam int unsigned MAX_WAIT = 3;
  localparam int unsigned Words    = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          p_req, p_we;
  logic [31:0]   p_addr;
  logic [DW-1:0] p_wdata, p_rdata;
  logic          stall_req;
  logic          x_valid, x_ready, x_we;
  logic [AW-1:0] x_addr;
  logic [DW-1:0] x_wdata;
  logic          x_rvalid;
  logic [DW-1:0] x_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd, mem_rd;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] ram    [Words];
  logic [DW-1:0] shadow [Words];
  logic [DW-1:0] expQ   [$];
  int            mWait;
  bit            lastGrant;

  always #5 clk = ~clk;

  risc_dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_rdata(p_rdata), .stall_req(stall_req),
    .x_valid(x_valid), .x_ready(x_ready), .x_we(x_we), .x_addr(x_addr),
    .x_wdata(x_wdata), .x_rvalid(x_rvalid), .x_rdata(x_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // Synchronous-write, combinational-read RAM
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wd;
  end
  assign mem_rd = ram[mem_addr];

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Check combinational ports at mid-cycle and advance the reference model
  task automatic predict();
    bit            g;
    bit            we;
    logic [AW-1:0] pa;
    logic [AW-1:0] wa;
    @(negedge clk);
    pa = p_addr[AW+1:2];
    g  = x_valid && (!p_req || mWait == int'(MAX_WAIT));
    we = g ? x_we : (p_req && p_we);
    wa = g ? x_addr : pa;
    check_eq("x_ready", DW'(x_ready), DW'(g));
    check_eq("stall_req", DW'(stall_req), DW'(p_req && g));
    check_eq("mem_we", DW'(mem_we), DW'(we));
    if (g || p_req) begin
      check_eq("mem_addr", DW'(mem_addr), DW'(wa));
      check_eq("p_rdata", p_rdata, shadow[wa]);
    end
    if (we) check_eq("mem_wd", mem_wd, g ? x_wdata : p_wdata);
    if (g && !x_we) expQ.push_back(shadow[x_addr]);
    if (we) shadow[wa] = g ? x_wdata : p_wdata;
    if (!x_valid || g) mWait = 0;
    else if (mWait < int'(MAX_WAIT)) mWait++;
    lastGrant = g;
  endtask

  // After the edge, the registered response must match the scoreboard
  task automatic respond();
    @(posedge clk);
    #1;
    check_eq("x_rvalid", DW'(x_rvalid), DW'(expQ.size() != 0));
    if (x_rvalid && expQ.size() != 0) check_eq("x_rdata", x_rdata, expQ.pop_front());
  endtask

  task automatic cycle();
    predict();
    respond();
  endtask

  localparam logic [DW-1:0] ValA = 32'hA5A5_0001;
  localparam logic [DW-1:0] ValB = 32'h0B0B_0002;

  initial begin
    for (int i = 0; i < int'(Words); i++) begin
      ram[i]    = DW'(i) * 32'h0101_0101 ^ 32'h5A5A_0000;
      shadow[i] = DW'(i) * 32'h0101_0101 ^ 32'h5A5A_0000;
    end
    mWait = 0;
    rst = 1'b1;
    p_req = 1'b0; p_we = 1'b0; p_addr = '0; p_wdata = '0;
    x_valid = 1'b1; x_we = 1'b0; x_addr = 6'd3; x_wdata = '0;

    // Reset: registered outputs forced low, combinational arbitration still live
    #3;
    check_eq("rst_rvalid", DW'(x_rvalid), '0);
    check_eq("rst_rdata", x_rdata, '0);
    check_eq("rst_xready_idle_pipe", DW'(x_ready), DW'(1));
    p_req = 1'b1;
    #1;
    check_eq("rst_xready_busy_pipe", DW'(x_ready), '0);
    check_eq("rst_stall", DW'(stall_req), '0);
    x_valid = 1'b0; p_req = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rst_rvalid_after_edge", DW'(x_rvalid), '0);
    rst = 1'b0;
    cycle();

    // Pipeline store to byte 0x10 with external idle
    p_req = 1'b1; p_we = 1'b1; p_addr = 32'h10; p_wdata = 32'hDEAD_BEEF;
    predict();
    check_eq("pstore_addr", DW'(mem_addr), DW'(4));
    respond();
    p_req = 1'b0; p_we = 1'b0;

    // External read of word 4 with the pipeline idle
    x_valid = 1'b1; x_we = 1'b0; x_addr = 6'd4;
    cycle();
    x_valid = 1'b0;
    predict();
    respond();
    check_eq("xread_beef", x_rdata, 32'hDEAD_BEEF);

    // Contention: external refused MAX_WAIT cycles, then preempts, then waits again
    p_req = 1'b1; p_we = 1'b0; p_addr = 32'h0;
    x_valid = 1'b1; x_we = 1'b0; x_addr = 6'd4;
    for (int i = 0; i < 8; i++) begin
      cycle();
      check_eq("preempt_pattern", DW'(lastGrant), DW'((i % 4) == 3));
    end

    // Pipeline store and preempting external write to the same word
    p_we = 1'b1; p_addr = 32'd5 << 2; p_wdata = ValA;
    x_we = 1'b1; x_addr = 6'd5; x_wdata = ValB;
    for (int i = 0; i < 4; i++) cycle();
    check_eq("collide_grant", DW'(lastGrant), DW'(1));
    check_eq("collide_ext_word", ram[5], ValB);
    x_valid = 1'b0;
    cycle();
    check_eq("collide_final_word", ram[5], ValA);
    p_req = 1'b0; p_we = 1'b0;
    x_valid = 1'b1; x_we = 1'b0; x_addr = 6'd5;
    cycle();
    x_valid = 1'b0;
    cycle();

    // Reset pulsed mid-cycle while a read response is outstanding
    x_valid = 1'b1; x_we = 1'b0; x_addr = 6'd4;
    cycle();
    predict();
    #2 rst = 1'b1;
    #1;
    check_eq("midrst_rvalid", DW'(x_rvalid), '0);
    check_eq("midrst_rdata", x_rdata, '0);
    expQ.delete();
    mWait = 0;
    x_valid = 1'b0;
    @(posedge clk);
    #1;
    check_eq("midrst_rvalid_edge", DW'(x_rvalid), '0);
    rst = 1'b0;
    cycle();
    cycle();

    // Back-to-back external reads of words 0..4
    for (int i = 0; i < 5; i++) begin
      x_valid = 1'b1; x_we = 1'b0; x_addr = AW'(i);
      cycle();
      check_eq("b2b_accept", DW'(lastGrant), DW'(1));
    end
    x_valid = 1'b0;
    cycle();

    // Random traffic; external request held until accepted
    for (int n = 0; n < 300; n++) begin
      if (!x_valid || lastGrant) begin
        x_valid = 1'($urandom_range(0, 1));
        x_we    = 1'($urandom_range(0, 1));
        x_addr  = AW'($urandom());
        x_wdata = $urandom();
      end
      p_req   = 1'($urandom_range(0, 3) != 0);
      p_we    = 1'($urandom_range(0, 1));
      p_addr  = $urandom();
      p_wdata = $urandom();
      cycle();
    end
    x_valid = 1'b0; p_req = 1'b0;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/risc_dmem_arbiter.md
RISC_DMEM_ARBITER -- requirements
Module: risc_dmem_arbiter

Interface
REQ-001 Parameter AW, default 6: data memory word-address width (64 words).
REQ-002 Parameter DW, default 32: data word width.
REQ-003 Parameter MAX_WAIT, default 3, legal range 1..15: number of cycles the external port may be refused before it preempts the pipeline.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 p_req  input  1  pipeline MEM stage has an access this cycle (load or store).
REQ-007 p_we  input  1  pipeline access is a store.
REQ-008 p_addr  input  32  pipeline byte address; the word index used is p_addr[AW+1:2].
REQ-009 p_wdata  input  DW  pipeline store data.
REQ-010 p_rdata  output  DW  pipeline load data, combinational copy of mem_rd.
REQ-011 stall_req  output  1  request to the hazard unit to stall F/D/E/M and hold the MEM-stage access.
REQ-012 x_valid  input  1  external (loader/debug) request valid.
REQ-013 x_ready  output  1  external request accepted this cycle.
REQ-014 x_we  input  1  external access is a write.
REQ-015 x_addr  input  AW  external word address.
REQ-016 x_wdata  input  DW  external write data.
REQ-017 x_rvalid  output  1  registered external read response valid.
REQ-018 x_rdata  output  DW  registered external read data.
REQ-019 mem_we  output  1  memory write enable (the memory writes synchronously).
REQ-020 mem_addr  output  AW  memory word address.
REQ-021 mem_wd  output  DW  memory write data.
REQ-022 mem_rd  input  DW  memory combinational read data.

Function
REQ-023 The block SHALL keep a wait counter wait_cnt, 4 bits wide, that saturates at MAX_WAIT.
REQ-024 ext_grant SHALL equal x_valid AND (NOT p_req OR wait_cnt == MAX_WAIT).
- It is combinational.
- x_ready SHALL equal ext_grant.
REQ-025 When ext_grant = 1, the memory port SHALL be driven from the external port:
- mem_addr = x_addr
- mem_wd = x_wdata
- mem_we = x_we
REQ-026 When ext_grant = 0, the memory port SHALL be driven from the pipeline port:
- mem_addr = p_addr[AW+1:2]
- mem_wd = p_wdata
- mem_we = p_req AND p_we
REQ-027 stall_req SHALL equal p_req AND ext_grant.
- The pipeline store is suppressed that cycle.
- The pipeline repeats the access on the next cycle.
REQ-028 wait_cnt next-state rules:
- Clears to 0 when x_valid = 0 or ext_grant = 1.
- Otherwise increments by 1, saturating at MAX_WAIT.
REQ-029 Preemption guarantee: after a preemption wait_cnt = 0, so back-to-back preemptions are impossible. With p_req held high, the pipeline gets at least MAX_WAIT grants between any two external grants.
REQ-030 An accepted external read (x_valid AND x_ready AND NOT x_we) SHALL:
- set x_rvalid = 1 and x_rdata = mem_rd on the next edge;
- otherwise x_rvalid = 0 on the next edge, and x_rdata holds its value.
REQ-031 An accepted external write SHALL complete in the grant cycle and produce no response (x_rvalid stays 0).
REQ-032 The external master SHALL hold x_valid, x_we, x_addr and x_wdata stable until x_ready = 1. The arbiter does not check this.
REQ-033 p_rdata SHALL equal mem_rd at all times. It is valid for the pipeline only when stall_req = 0.
REQ-034 When p_req = 0 and x_valid = 0:
- mem_we = 0
- stall_req = 0
- x_ready = 0
REQ-035 Back-to-back external requests with p_req = 0 SHALL be accepted every cycle. Reads return one cycle after acceptance, one response per cycle.

Reset
REQ-036 While rst = 1, asynchronously and independent of clk, the block SHALL force:
- wait_cnt = 0
- x_rvalid = 0
- x_rdata = 0
REQ-037 A read accepted in the cycle in which rst rises SHALL produce no response. x_rvalid is 0 on the first edge after rst falls, unless a new read is accepted in that cycle.
REQ-038 Combinational outputs SHALL follow REQ-024 to REQ-027 during reset. Because wait_cnt = 0, the external port is granted only when p_req = 0.

Verification
REQ-039 Idle external, pipeline store (p_req=1, p_we=1, p_addr=0x10, p_wdata=0xDEADBEEF) -> mem_we=1, mem_addr=4, stall_req=0, x_ready=0.
REQ-040 p_req=0, external read of x_addr=4 -> x_ready=1 in the same cycle; next cycle x_rvalid=1 and x_rdata=0xDEADBEEF.
REQ-041 MAX_WAIT=3, p_req and x_valid both held high -> x_ready=0 for 3 cycles, then x_ready=1 and stall_req=1 in the 4th cycle, then pipeline granted with wait_cnt=0.
REQ-042 Simultaneous pipeline store and preempting external write to the same word -> only x_wdata is written that cycle; the pipeline store lands on the following cycle, final word = p_wdata.
REQ-043 External read accepted, rst pulsed high mid-cycle before the next edge -> x_rvalid=0 and x_rdata=0 immediately; no response after reset release.
REQ-044 p_req=0, x_valid high for 5 consecutive reads of addresses 0..4 -> 5 accepts on consecutive cycles and 5 consecutive x_rvalid pulses with matching data.
